// File: rtl/intra_mode_selector.sv
// Minimum-SAD intra mode selector: picks the cheapest predictor per block, forwards its
// residues over a valid/ready output register, records modes in a map and sums group SADs.
module intra_mode_selector #(
    parameter int NUM_MODES = 3,
    parameter int SAD_W     = 8,
    parameter int RES_W     = 8,
    parameter int MB_PIX    = 64,
    parameter int GROUP     = 16,
    parameter int SUM_W     = 12,
    parameter int NUM_MB    = 14400,
    parameter int MB_AW     = 14,
    localparam int MODE_W   = $clog2(NUM_MODES)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_MODES*SAD_W-1:0]        sads,
    input  logic [NUM_MODES*MB_PIX*RES_W-1:0] residues,
    input  logic [MB_AW-1:0]                  mbnumber,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [MODE_W-1:0]                 mode,
    output logic [MB_AW-1:0]                  mb_out,
    output logic [MB_PIX*RES_W-1:0]           res_out,
    output logic                              sum_valid,
    output logic [SUM_W-1:0]                  sum,
    output logic                              sum_sat,
    output logic                              mb_err,
    input  logic [MB_AW-1:0]                  rd_addr,
    output logic [MODE_W-1:0]                 rd_mode
);

    localparam int BLK_W = MB_PIX * RES_W;
    localparam int ADD_W = ((SUM_W > SAD_W) ? SUM_W : SAD_W) + 1;
    localparam int CNT_W = $clog2(GROUP + 1);
    localparam int IDX_W = (NUM_MB > 1) ? $clog2(NUM_MB) : 1;
    localparam logic [MB_AW:0]     NUM_MB_L = (MB_AW + 1)'(NUM_MB);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(GROUP - 1);
    localparam logic [SUM_W-1:0]   SUM_MAX  = '1;

    // Returns {saturated, clamped sum}; the add is done one bit wider than either operand.
    function automatic logic [SUM_W:0] sat_add(input logic [SUM_W-1:0] a,
                                               input logic [SAD_W-1:0] b);
        logic [ADD_W-1:0] wide;
        wide = ADD_W'(a) + ADD_W'(b);
        if (wide > ADD_W'(SUM_MAX))
            return {1'b1, SUM_MAX};
        return {1'b0, wide[SUM_W-1:0]};
    endfunction

    logic [MODE_W-1:0] sel_p0;
    logic [SAD_W-1:0]  min_sad_p0;
    logic [BLK_W-1:0]  res_sel_p0;
    logic              in_range_p0;
    logic [SUM_W:0]    add_p0;
    logic              accept;

    logic [SUM_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              sat_flag;
    logic [MODE_W-1:0] map_mem [NUM_MB];

    // Stage p0: combinational argmin; strict less-than keeps the lowest index on ties
    always_comb begin
        sel_p0     = '0;
        min_sad_p0 = sads[SAD_W-1:0];
        for (int k = 1; k < NUM_MODES; k++) begin
            if (sads[k*SAD_W +: SAD_W] < min_sad_p0) begin
                min_sad_p0 = sads[k*SAD_W +: SAD_W];
                sel_p0     = MODE_W'(k);
            end
        end
    end

    always_comb begin
        res_sel_p0 = residues[BLK_W-1:0];
        for (int k = 1; k < NUM_MODES; k++) begin
            if (sel_p0 == MODE_W'(k))
                res_sel_p0 = residues[k*BLK_W +: BLK_W];
        end
    end

    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign in_range_p0 = {1'b0, mbnumber} < NUM_MB_L;
    assign add_p0      = sat_add(acc, min_sad_p0);

    // Stage p1: output register, held while the downstream stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            mode      <= '0;
            mb_out    <= '0;
            res_out   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            mode      <= sel_p0;
            mb_out    <= mbnumber;
            res_out   <= res_sel_p0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Map storage carries no reset so it can map onto block RAM
    always_ff @(posedge clk) begin
        if (accept && in_range_p0)
            map_mem[mbnumber[IDX_W-1:0]] <= sel_p0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rd_mode <= '0;
        else if ({1'b0, rd_addr} < NUM_MB_L)
            rd_mode <= map_mem[rd_addr[IDX_W-1:0]];
        else
            rd_mode <= '0;
    end

    // Stage p1: group accumulation; the closing block's SAD goes straight into sum
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            cnt       <= '0;
            sat_flag  <= 1'b0;
            sum       <= '0;
            sum_sat   <= 1'b0;
            sum_valid <= 1'b0;
            mb_err    <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            mb_err    <= accept && !in_range_p0;
            if (accept) begin
                if (cnt == CNT_LAST) begin
                    sum       <= add_p0[SUM_W-1:0];
                    sum_sat   <= sat_flag | add_p0[SUM_W];
                    sum_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    sat_flag  <= 1'b0;
                end else begin
                    acc      <= add_p0[SUM_W-1:0];
                    sat_flag <= sat_flag | add_p0[SUM_W];
                    cnt      <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_intra_mode_selector.sv
// Bench for intra_mode_selector: table vectors, a random scoreboard run and hand sequences
// on a default instance, plus a 9-mode / 16-sample / GROUP=17 instance.
module tb_intra_mode_selector;

    localparam int NM = 3, SW = 8, RW = 8, PIX = 64, GRP = 16, SUMW = 12;
    localparam int NMB = 14400, AW = 14, MW = 2, BLK = PIX * RW;
    localparam int NM_B = 9, PIX_B = 16, GRP_B = 17, MW_B = 4, BLK_B = PIX_B * RW;
    localparam int SMAX = 4095;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              in_valid, in_ready, out_valid, out_ready;
    logic [NM*SW-1:0]  sads;
    logic [NM*BLK-1:0] residues;
    logic [AW-1:0]     mbnumber, mb_out, rd_addr;
    logic [MW-1:0]     mode, rd_mode;
    logic [BLK-1:0]    res_out;
    logic              sum_valid, sum_sat, mb_err;
    logic [SUMW-1:0]   sum;

    logic                in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [NM_B*SW-1:0]  sads_b;
    logic [NM_B*BLK_B-1:0] residues_b;
    logic [AW-1:0]       mbnumber_b, mb_out_b, rd_addr_b;
    logic [MW_B-1:0]     mode_b, rd_mode_b;
    logic [BLK_B-1:0]    res_out_b;
    logic                sum_valid_b, sum_sat_b, mb_err_b;
    logic [SUMW-1:0]     sum_b;

    intra_mode_selector dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sads(sads), .residues(residues), .mbnumber(mbnumber),
        .out_valid(out_valid), .out_ready(out_ready), .mode(mode), .mb_out(mb_out),
        .res_out(res_out), .sum_valid(sum_valid), .sum(sum), .sum_sat(sum_sat),
        .mb_err(mb_err), .rd_addr(rd_addr), .rd_mode(rd_mode)
    );

    intra_mode_selector #(.NUM_MODES(NM_B), .MB_PIX(PIX_B), .GROUP(GRP_B)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .sads(sads_b), .residues(residues_b), .mbnumber(mbnumber_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .mode(mode_b), .mb_out(mb_out_b),
        .res_out(res_out_b), .sum_valid(sum_valid_b), .sum(sum_b), .sum_sat(sum_sat_b),
        .mb_err(mb_err_b), .rd_addr(rd_addr_b), .rd_mode(rd_mode_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: queue of blocks awaiting downstream, list of group SADs, map by address
    typedef struct {
        int             m;
        int             mb;
        logic [BLK-1:0] r;
    } blk_t;

    blk_t            oq[$];
    int              gq[$];
    int              map_m[int];
    logic [SUMW-1:0] exp_sum = '0;
    bit              last_acc;

    function automatic int ref_min(input logic [NM*SW-1:0] s);
        int m = 1 << SW;
        for (int k = 0; k < NM; k++)
            if (int'(s[k*SW +: SW]) < m) m = int'(s[k*SW +: SW]);
        return m;
    endfunction

    function automatic int ref_argmin(input logic [NM*SW-1:0] s);
        int m = ref_min(s);
        for (int k = 0; k < NM; k++)
            if (int'(s[k*SW +: SW]) == m) return k;
        return 0;
    endfunction

    function automatic logic [NM*BLK-1:0] rand_res();
        logic [NM*BLK-1:0] r;
        for (int i = 0; i < NM*BLK/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Minimum v at mode m, every other mode strictly larger unless v is already the ceiling
    function automatic logic [NM*SW-1:0] make_sads(input int v, input int m);
        logic [NM*SW-1:0] s;
        for (int k = 0; k < NM; k++)
            s[k*SW +: SW] = (k == m || v >= 255) ? SW'(v) : SW'($urandom_range(v + 1, 255));
        return s;
    endfunction

    // One clock of the default instance; entered and left at posedge+1 with inputs driven
    task automatic cycle();
        blk_t b;
        int   idx, ra, total;
        bit   drain, rd_known, exp_sv, exp_sat, exp_err;
        int   exp_rd;
        #4;
        chk("in_ready", in_ready, (oq.size() == 0) || out_ready);
        last_acc = in_valid && ((oq.size() == 0) || out_ready);
        drain    = (oq.size() != 0) && out_ready;
        ra       = int'(rd_addr);
        rd_known = (ra >= NMB) || map_m.exists(ra);
        exp_rd   = (ra < NMB && map_m.exists(ra)) ? map_m[ra] : 0;
        exp_sv   = 1'b0;
        exp_sat  = 1'b0;
        exp_err  = 1'b0;
        if (drain) void'(oq.pop_front());
        if (last_acc) begin
            idx  = ref_argmin(sads);
            b.m  = idx;
            b.mb = int'(mbnumber);
            b.r  = residues[idx*BLK +: BLK];
            oq.push_back(b);
            if (int'(mbnumber) < NMB) map_m[int'(mbnumber)] = idx;
            else exp_err = 1'b1;
            gq.push_back(ref_min(sads));
            if (gq.size() == GRP) begin
                total   = gq.sum();
                exp_sum = SUMW'((total > SMAX) ? SMAX : total);
                exp_sat = total > SMAX;
                exp_sv  = 1'b1;
                gq.delete();
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, oq.size() != 0);
        if (oq.size() != 0) begin
            chk("mode", mode, oq[0].m);
            chk("mb_out", mb_out, oq[0].mb);
            chk("res_out", res_out, oq[0].r);
        end
        chk("sum_valid", sum_valid, exp_sv);
        chk("sum", sum, exp_sum);
        if (exp_sv) chk("sum_sat", sum_sat, exp_sat);
        chk("mb_err", mb_err, exp_err);
        if (rd_known) chk("rd_mode", rd_mode, exp_rd);
    endtask

    // Asynchronous reset mid-cycle; outputs checked before any clock edge
    task automatic reset_pulse();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mode", mode, 0);
        chk("rst_mb_out", mb_out, 0);
        chk("rst_res_out", res_out, 0);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_sum_sat", sum_sat, 0);
        chk("rst_mb_err", mb_err, 0);
        chk("rst_rd_mode", rd_mode, 0);
        oq.delete();
        gq.delete();
        exp_sum = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        logic [SW-1:0] s0, s1, s2;
        int            exp_mode;
    } tv_t;

    tv_t tv[8];

    initial begin
        tv[0] = '{8'd40,  8'd12,  8'd12,  1};
        tv[1] = '{8'd7,   8'd7,   8'd7,   0};
        tv[2] = '{8'd0,   8'd255, 8'd255, 0};
        tv[3] = '{8'd255, 8'd254, 8'd255, 1};
        tv[4] = '{8'd200, 8'd100, 8'd50,  2};
        tv[5] = '{8'd1,   8'd0,   8'd0,   1};
        tv[6] = '{8'd255, 8'd255, 8'd0,   2};
        tv[7] = '{8'd255, 8'd255, 8'd255, 0};

        reset = 1'b0;
        in_valid = 0; out_ready = 0; sads = '0; residues = '0; mbnumber = '0; rd_addr = '0;
        in_valid_b = 0; out_ready_b = 1; sads_b = '0; residues_b = '0; mbnumber_b = '0;
        rd_addr_b = '0;
        @(posedge clk);
        #1;
        chk("init_out_valid", out_valid, 0);
        chk("init_sum", sum, 0);
        chk("init_sum_valid", sum_valid, 0);
        chk("init_mb_err", mb_err, 0);
        chk("init_rd_mode", rd_mode, 0);
        chk("init_res_out", res_out, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Wide instance: 17 saturating blocks, then a minimum at mode 8
        in_valid_b = 1;
        sads_b = '1;
        for (int i = 0; i < GRP_B; i++) begin
            for (int w = 0; w < NM_B*BLK_B/32; w++) residues_b[w*32 +: 32] = $urandom;
            mbnumber_b = AW'(100 + i);
            @(posedge clk);
            #1;
            chk("b_sum_valid", sum_valid_b, i == GRP_B - 1);
        end
        chk("b_sum_4095", sum_b, 4095);
        chk("b_sum_sat", sum_sat_b, 1);
        for (int k = 0; k < NM_B; k++) sads_b[k*SW +: SW] = (k == 8) ? 8'd3 : 8'd50;
        for (int w = 0; w < NM_B*BLK_B/32; w++) residues_b[w*32 +: 32] = $urandom;
        mbnumber_b = AW'(5);
        @(posedge clk);
        #1;
        chk("b_mode8", mode_b, 8);
        chk("b_res8", res_out_b, residues_b[8*BLK_B +: BLK_B]);
        chk("b_mb_out", mb_out_b, 5);
        chk("b_sum_valid_off", sum_valid_b, 0);
        in_valid_b = 0;
        rd_addr_b = AW'(5);
        @(posedge clk);
        #1;
        chk("b_rd_mode", rd_mode_b, 8);
        chk("b_drained", out_valid_b, 0);
        chk("b_mb_err", mb_err_b, 0);
        chk("b_in_ready", in_ready_b, 1);

        // Table of argmin / tie-break vectors
        out_ready = 1;
        rd_addr = AW'(NMB);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1;
            sads = {tv[i].s2, tv[i].s1, tv[i].s0};
            residues = rand_res();
            mbnumber = AW'(1000 + i);
            cycle();
            chk("table_mode", mode, tv[i].exp_mode);
        end
        in_valid = 0;
        cycle();

        // Backpressure: one block held for 5 stalled cycles, the next loads on release
        in_valid = 1; out_ready = 0;
        sads = make_sads(30, 2); residues = rand_res(); mbnumber = AW'(2000);
        cycle();
        sads = make_sads(40, 1); residues = rand_res(); mbnumber = AW'(2001);
        for (int i = 0; i < 5; i++) cycle();
        out_ready = 1;
        cycle();
        chk("bp_second_mb", mb_out, 2001);
        in_valid = 0;
        cycle();

        // Random traffic on both sides of the handshake
        begin
            int accepted = 0;
            int cyc = 0;
            while (accepted < 20 && cyc < 400) begin
                in_valid  = $urandom_range(0, 2) != 0;
                out_ready = $urandom_range(0, 2) != 0;
                sads      = NM*SW'($urandom);
                residues  = rand_res();
                mbnumber  = AW'($urandom_range(3000, 3999));
                rd_addr   = AW'($urandom_range(3000, 3999));
                cycle();
                if (last_acc) accepted++;
                cyc++;
            end
            chk("rand_accepts", accepted, 20);
        end
        in_valid = 0; out_ready = 1;
        cycle();
        cycle();

        // Group sums from a clean accumulator
        reset_pulse();
        in_valid = 1; rd_addr = AW'(NMB);
        for (int i = 0; i < GRP; i++) begin
            sads = make_sads(100, i % 3); residues = rand_res(); mbnumber = AW'(200 + i);
            cycle();
        end
        chk("sum_1600", sum, 1600);
        chk("sat_1600", sum_sat, 0);
        for (int i = 0; i < GRP; i++) begin
            sads = make_sads(255, 0); residues = rand_res(); mbnumber = AW'(300 + i);
            cycle();
        end
        chk("sum_4080", sum, 4080);
        chk("sat_4080", sum_sat, 0);

        // Mode map write / read-back, same-cycle read, out-of-range index
        for (int i = 0; i < 10; i++) begin
            sads = make_sads(20, i % 3); residues = rand_res(); mbnumber = AW'(i);
            cycle();
        end
        in_valid = 0;
        for (int i = 0; i < 10; i++) begin
            rd_addr = AW'(i);
            cycle();
            chk("map_read", rd_mode, i % 3);
        end
        in_valid = 1; rd_addr = AW'(3); mbnumber = AW'(3);
        sads = make_sads(20, 1); residues = rand_res();
        cycle();
        chk("map_rw_old", rd_mode, 0);
        in_valid = 0;
        cycle();
        chk("map_rw_new", rd_mode, 1);
        in_valid = 1; mbnumber = AW'(NMB); rd_addr = AW'(NMB);
        sads = make_sads(15, 2); residues = rand_res();
        cycle();
        chk("oor_mb_err", mb_err, 1);
        chk("oor_forwarded", mb_out, NMB);
        in_valid = 0;
        cycle();

        // Reset partway through a group with a full output register
        in_valid = 1;
        for (int i = 0; i < 7; i++) begin
            sads = make_sads(50, i % 3); residues = rand_res(); mbnumber = AW'(400 + i);
            cycle();
        end
        chk("pre_rst_valid", out_valid, 1);
        reset_pulse();
        for (int i = 0; i < GRP; i++) begin
            sads = make_sads(10, i % 3); residues = rand_res(); mbnumber = AW'(500 + i);
            cycle();
        end
        chk("sum_160", sum, 160);
        in_valid = 0;
        for (int i = 0; i < 10; i++) begin
            rd_addr = AW'(i);
            cycle();
        end
        chk("map_kept_9", rd_mode, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
